// File: rtl/uart_baud_tx.sv
// uart_baud_tx: UART transmitter with two selectable baud rates and fixed-pattern data.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_baud_tx #(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD_FAST = 9600,
    parameter int BAUD_SLOW = 2400
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic baud_sel,
    input  logic word8,
    input  logic stop2,
    input  logic bitmode,
    output logic txd,
    output logic rts,
    output logic busy,
    output logic finished
);
    localparam int DIV_FAST = CLK_HZ / BAUD_FAST;
    localparam int DIV_SLOW = CLK_HZ / BAUD_SLOW;
    localparam int DIV_MAX  = (DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW;
    localparam int CW       = $clog2(DIV_MAX + 1);
    localparam logic [CW-1:0] LAST_FAST = CW'(DIV_FAST - 1);
    localparam logic [CW-1:0] LAST_SLOW = CW'(DIV_SLOW - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state, state_n;
    logic [CW-1:0] baud_cnt, baud_n;
    logic [2:0]    bit_cnt, bit_n;
    logic          cfg_sel, cfg_w8, cfg_s2, cfg_bm;
    logic          sel_n, w8_n, s2_n, bm_n;
    logic          fin_q, fin_n;
    logic [CW-1:0] baud_last;
    logic          bit_end;
    logic [2:0]    data_last;
    logic [2:0]    stop_last;

    // Divisor follows the configuration latched at acceptance
    assign baud_last = cfg_sel ? LAST_SLOW : LAST_FAST;
    assign bit_end   = (baud_cnt == baud_last);
    assign data_last = cfg_w8 ? 3'd7 : 3'd6;
    assign stop_last = {2'b00, cfg_s2};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            cfg_sel  <= 1'b0;
            cfg_w8   <= 1'b0;
            cfg_s2   <= 1'b0;
            cfg_bm   <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            cfg_sel  <= sel_n;
            cfg_w8   <= w8_n;
            cfg_s2   <= s2_n;
            cfg_bm   <= bm_n;
            fin_q    <= fin_n;
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = '0;
        bit_n   = bit_cnt;
        sel_n   = cfg_sel;
        w8_n    = cfg_w8;
        s2_n    = cfg_s2;
        bm_n    = cfg_bm;
        fin_n   = 1'b0;
        if (state != IDLE) begin
            baud_n = bit_end ? '0 : baud_cnt + CW'(1);
        end
        unique case (state)
            IDLE: begin
                bit_n = '0;
                if (start) begin
                    state_n = START;
                    sel_n   = baud_sel;
                    w8_n    = word8;
                    s2_n    = stop2;
                    bm_n    = bitmode;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    bit_n   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == data_last) begin
                        bit_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    bit_n   = '0;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt == stop_last) begin
                        state_n = IDLE;
                        bit_n   = '0;
                        fin_n   = 1'b1;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        txd = 1'b1;
        unique case (state)
            START:   txd = 1'b0;
            DATA:    txd = cfg_bm;
`ifdef UART_TX_PARITY_EN
            // Even parity of N identical bits: set only for 7 ones
            PARITY:  txd = cfg_bm & ~cfg_w8;
`endif
            default: txd = 1'b1;
        endcase
    end

    assign busy     = (state != IDLE);
    assign rts      = busy;
    assign finished = fin_q;
endmodule

// File: tb/tb_uart_baud_tx.sv
// Scoreboard bench for uart_baud_tx with scaled-down divisors (DIV 10 and 27).
// Stimulus pushes expected frames; a negedge monitor pops and checks them.
module tb_uart_baud_tx;
    localparam int CLK_HZ = 1000;
    localparam int BF     = 100;
    localparam int BS     = 37;
    localparam int DF     = 10;
    localparam int DS     = 27;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic baud_sel = 1'b0;
    logic word8 = 1'b0;
    logic stop2 = 1'b0;
    logic bitmode = 1'b0;
    logic txd, rts, busy, finished;

    uart_baud_tx #(
        .CLK_HZ(CLK_HZ),
        .BAUD_FAST(BF),
        .BAUD_SLOW(BS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .baud_sel(baud_sel),
        .word8(word8),
        .stop2(stop2),
        .bitmode(bitmode),
        .txd(txd),
        .rts(rts),
        .busy(busy),
        .finished(finished)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        int          div;
        int          nbits;
        logic [15:0] bits;
        bit          abort;
        bit          b2b;
    } frame_t;

    frame_t q[$];
    int errors = 0;
    int checks = 0;
    int issued = 0;
    int frames_done = 0;
    int fin_seen = 0;
    int fin_exp = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic frame_t mk(input int id, input bit sel, input bit w8,
                                  input bit s2, input bit bm,
                                  input bit abort, input bit b2b);
        frame_t f;
        int n;
        int k;
        f.id    = id;
        f.div   = sel ? DS : DF;
        f.abort = abort;
        f.b2b   = b2b;
        f.bits  = '1;
        f.bits[0] = 1'b0;
        n = w8 ? 8 : 7;
        k = 1;
        for (int i = 0; i < n; i++) begin
            f.bits[k] = bm;
            k++;
        end
`ifdef UART_TX_PARITY_EN
        f.bits[k] = w8 ? 1'b0 : bm;
        k++;
`endif
        k = k + (s2 ? 2 : 1);
        f.nbits = k;
        return f;
    endfunction

    // Monitor: frame boundaries follow busy, sampled on the falling edge
    frame_t cur;
    bit active = 1'b0;
    int cnt = 0;
    int bad_tx = -1;
    int bad_rts = -1;
    int cyc = 0;
    int fin_cyc = -100;

    always @(negedge clk) begin
        cyc++;
        if (finished) fin_seen++;
        if (!active && busy) begin
            if (q.size() == 0) begin
                chk("unexpected_frame", 1, 0);
            end else begin
                cur = q.pop_front();
                active = 1'b1;
                cnt = 0;
                bad_tx = -1;
                bad_rts = -1;
                if (cur.b2b)
                    chk($sformatf("f%0d_gap_after_finished", cur.id),
                        cyc - fin_cyc, 1);
            end
        end
        if (active) begin
            if (busy) begin
                if (bad_tx < 0) begin
                    if (cnt / cur.div >= cur.nbits) bad_tx = cnt;
                    else if (txd !== cur.bits[cnt / cur.div]) bad_tx = cnt;
                end
                if (bad_rts < 0 && rts !== 1'b1) bad_rts = cnt;
                cnt++;
            end else begin
                active = 1'b0;
                chk($sformatf("f%0d_txd_first_bad_cycle", cur.id), bad_tx, -1);
                chk($sformatf("f%0d_rts_first_bad_cycle", cur.id), bad_rts, -1);
                if (cur.abort) begin
                    chk($sformatf("f%0d_abort_finished", cur.id),
                        int'(finished), 0);
                end else begin
                    chk($sformatf("f%0d_len", cur.id), cnt, cur.nbits * cur.div);
                    chk($sformatf("f%0d_finished", cur.id), int'(finished), 1);
                end
                frames_done++;
            end
        end
        if (finished) fin_cyc = cyc;
    end

    task automatic send(input int id, input bit sel, input bit w8,
                        input bit s2, input bit bm);
        @(posedge clk);
        #2;
        baud_sel = sel;
        word8    = w8;
        stop2    = s2;
        bitmode  = bm;
        start    = 1'b1;
        q.push_back(mk(id, sel, w8, s2, bm, 1'b0, 1'b0));
        issued++;
        fin_exp++;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (frames_done == issued && !busy) break;
            @(posedge clk);
        end
        chk(name, frames_done, issued);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        frame_t f;
        #12;
        chk("reset_txd", int'(txd), 1);
        chk("reset_rts", int'(rts), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_finished", int'(finished), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Fast rate, 8 zeros, 1 stop: 10 bit periods of DIV 10
        send(1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_done("f1_timeout", 400);

        // Slow rate, 7 ones, 2 stop: truncated DIV 27
        send(2, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_done("f2_timeout", 800);

        // Re-pulse start and flip every config input mid-frame
        send(3, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (25) @(posedge clk);
        #2;
        start    = 1'b1;
        baud_sel = 1'b1;
        word8    = 1'b1;
        stop2    = 1'b1;
        bitmode  = 1'b0;
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done("f3_timeout", 400);

        // Reset in DATA aborts with no finished pulse
        @(posedge clk);
        #2;
        baud_sel = 1'b0;
        word8    = 1'b1;
        stop2    = 1'b0;
        bitmode  = 1'b0;
        start    = 1'b1;
        q.push_back(mk(4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        issued++;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (35) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_txd", int'(txd), 1);
        chk("abort_rts", int'(rts), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_finished", int'(finished), 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        wait_done("f4_timeout", 50);

        // First start after reset is accepted normally
        send(5, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_done("f5_timeout", 400);

        // start held across finished: frame 7 follows frame 6 with no gap
        @(posedge clk);
        #2;
        baud_sel = 1'b0;
        word8    = 1'b0;
        stop2    = 1'b0;
        bitmode  = 1'b0;
        start    = 1'b1;
        q.push_back(mk(6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        issued++;
        fin_exp++;
        @(posedge clk);
        #2;
        baud_sel = 1'b1;
        word8    = 1'b1;
        stop2    = 1'b1;
        bitmode  = 1'b1;
        f = mk(7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        q.push_back(f);
        issued++;
        fin_exp++;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (finished) break;
        end
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done("f7_timeout", 600);

        chk("finished_pulse_count", fin_seen, fin_exp);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_baud_tx.md
UART_BAUD_TX -- requirements
Module: uart_baud_tx

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_FAST, default 9600, baud rate when baud_sel=0.
REQ-003 The block SHALL have parameter BAUD_SLOW, default 2400, baud rate when baud_sel=1.
REQ-004 The block SHALL have port clk, input, 1, single system clock; all flops on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1, request to transmit one character.
REQ-007 The block SHALL have port baud_sel, input, 1, 0=BAUD_FAST, 1=BAUD_SLOW.
REQ-008 The block SHALL have port word8, input, 1, 0=7 data bits, 1=8 data bits.
REQ-009 The block SHALL have port stop2, input, 1, 0=1 stop bit, 1=2 stop bits.
REQ-010 The block SHALL have port bitmode, input, 1, character content: 0=all zeros, 1=all ones.
REQ-011 The block SHALL have port txd, output, 1, serial line, idle high.
REQ-012 The block SHALL have port rts, output, 1, 1=RTS ON for the duration of the frame.
REQ-013 The block SHALL have port busy, output, 1, frame in progress.
REQ-014 The block SHALL have port finished, output, 1, one-cycle pulse at end of frame.

Function
REQ-015 The divisor SHALL be DIV=CLK_HZ/BAUD truncated: 5208 (9600) or 20833 (2400) at defaults.
REQ-016 The baud counter SHALL run only while busy=1 and SHALL restart from 0 at frame acceptance, so every bit lasts exactly DIV clk cycles.
REQ-017 start SHALL be accepted only when busy=0, including the cycle finished=1; start while busy=1 SHALL be ignored.
REQ-018 On acceptance, baud_sel, word8, stop2 and bitmode SHALL be latched; later changes SHALL NOT affect the current frame.
REQ-019 The state machine SHALL use states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-020 On the cycle after acceptance, the block SHALL drive txd=0 (START), rts=1 and busy=1.
REQ-021 After one bit period, DATA SHALL send 7 or 8 bits LSB first, each equal to the latched bitmode.
REQ-022 STOP SHALL drive txd=1 for 1 or 2 bit periods per the latched stop2.
REQ-023 When the last stop period ends, the next cycle SHALL return to IDLE with rts=0, busy=0, finished=1 for exactly one cycle, and txd=1.
REQ-024 The frame length SHALL be (1+N+S)*DIV cycles, where N is the data bit count and S the stop bit count, plus 1 bit when parity is compiled in.
REQ-025 In IDLE, txd SHALL be 1, rts=0, busy=0.

Reset
REQ-026 rst=1 SHALL immediately force IDLE with txd=1, rts=0, busy=0, finished=0, baud and bit counters 0, and latched configuration 0.
REQ-027 Reset mid-frame SHALL abort the frame without emitting finished.
REQ-028 After rst deasserts, the first start SHALL be accepted normally.

Configuration
REQ-029 With macro UART_TX_PARITY_EN defined, one even-parity bit (XOR of the sent data bits: 0 for all-zeros; for all-ones, 1 with 7 bits and 0 with 8 bits) SHALL be sent for one bit period between DATA and STOP.
REQ-030 Without UART_TX_PARITY_EN, the PARITY state SHALL be absent and the frame SHALL go directly from DATA to STOP.

Verification
REQ-031 A bench SHALL cover: baud_sel=0, word8=1, stop2=0, bitmode=0, start pulse -> txd low 5208*9 cycles, high 5208, finished after 52080 cycles, rts high throughout.
REQ-032 A bench SHALL cover: baud_sel=1, word8=0, stop2=1, bitmode=1 -> start bit 20833 cycles low, then txd high 20833*9 cycles, frame 208330 cycles.
REQ-033 A bench SHALL cover: start re-pulsed mid-frame and baud_sel toggled mid-frame -> no restart, timing unchanged, single finished pulse.
REQ-034 A bench SHALL cover: rst asserted in DATA -> txd=1, rts=0, busy=0 asynchronously, no finished pulse.
REQ-035 A bench SHALL cover: start held high across finished -> next frame's start bit begins the cycle after finished.
REQ-036 A bench SHALL cover: UART_TX_PARITY_EN with word8=0, bitmode=1 -> parity bit high one period, frame 11*DIV cycles.
